// File: rtl/vedic_pkg.sv
// Shared widths, types and the 2x2 Urdhva cell for the vedic_eight_pipeline multiplier.
// Optional feature macro: VEDIC_VALID_EN (valid tracking alongside the data pipeline).
package vedic_pkg;

    localparam int unsigned OP_W     = 8;
    localparam int unsigned HALF_W   = 4;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned PPROD_W  = 8;
    localparam int unsigned CROSS_W  = PPROD_W + 1;

    typedef logic [OP_W-1:0]    operand_t;
    typedef logic [HALF_W-1:0]  half_t;
    typedef logic [PPROD_W-1:0] pprod_t;
    typedef logic [PROD_W-1:0]  product_t;

    // 2x2 Urdhva cell: vertical and crosswise bit products with explicit carries.
    function automatic logic [3:0] urdhva2(input logic [1:0] a, input logic [1:0] b);
        logic q0, q1, q2, q3, x0, x1, c1;
        q0 = a[0] & b[0];
        x0 = a[1] & b[0];
        x1 = a[0] & b[1];
        q1 = x0 ^ x1;
        c1 = x0 & x1;
        q2 = (a[1] & b[1]) ^ c1;
        q3 = a[1] & b[1] & c1;
        return {q3, q2, q1, q0};
    endfunction

endpackage

// File: rtl/vedic_four.sv
// Combinational 4x4 Vedic multiplier assembled from four 2x2 Urdhva cells.
module vedic_four
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0]  i_a,
    input  logic [HALF_W-1:0]  i_b,
    output logic [PPROD_W-1:0] o_p_c
);

    logic [3:0]         w_ll;
    logic [3:0]         w_lh;
    logic [3:0]         w_hl;
    logic [3:0]         w_hh;
    logic [PPROD_W-1:0] w_cross;

    assign w_ll = urdhva2(i_a[1:0], i_b[1:0]);
    assign w_lh = urdhva2(i_a[1:0], i_b[3:2]);
    assign w_hl = urdhva2(i_a[3:2], i_b[1:0]);
    assign w_hh = urdhva2(i_a[3:2], i_b[3:2]);

    assign w_cross = PPROD_W'(w_lh) + PPROD_W'(w_hl);
    assign o_p_c   = PPROD_W'(w_ll) + (w_cross << 2) + (PPROD_W'(w_hh) << 4);

endmodule

// File: rtl/vedic_eight_pipeline.sv
// Four-stage pipelined 8x8 Urdhva-Tiryagbhyam multiplier, one result per cycle.
// Optional macro VEDIC_VALID_EN adds in_valid/out_valid tracked through the pipeline.
module vedic_eight_pipeline
    import vedic_pkg::*;
(
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   i,
    input  logic [OP_W-1:0]   j,
    output logic [PROD_W-1:0] z
`ifdef VEDIC_VALID_EN
    ,
    input  logic              in_valid,
    output logic              out_valid
`endif
);

    operand_t             r_i;
    operand_t             r_j;
    pprod_t               r_ll;
    pprod_t               r_lh;
    pprod_t               r_hl;
    pprod_t               r_hh;
    logic [CROSS_W-1:0]   r_cross;
    pprod_t               r_low;
    pprod_t               r_high;
    product_t             r_z;

    pprod_t               w_ll;
    pprod_t               w_lh;
    pprod_t               w_hl;
    pprod_t               w_hh;

    vedic_four u_ll (.i_a(r_i[HALF_W-1:0]),    .i_b(r_j[HALF_W-1:0]),    .o_p_c(w_ll));
    vedic_four u_lh (.i_a(r_i[HALF_W-1:0]),    .i_b(r_j[OP_W-1:HALF_W]), .o_p_c(w_lh));
    vedic_four u_hl (.i_a(r_i[OP_W-1:HALF_W]), .i_b(r_j[HALF_W-1:0]),    .o_p_c(w_hl));
    vedic_four u_hh (.i_a(r_i[OP_W-1:HALF_W]), .i_b(r_j[OP_W-1:HALF_W]), .o_p_c(w_hh));

    // Operand capture, partial products, cross/low/high terms, final sum.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_i     <= '0;
            r_j     <= '0;
            r_ll    <= '0;
            r_lh    <= '0;
            r_hl    <= '0;
            r_hh    <= '0;
            r_cross <= '0;
            r_low   <= '0;
            r_high  <= '0;
            r_z     <= '0;
        end else begin
            r_i     <= i;
            r_j     <= j;
            r_ll    <= w_ll;
            r_lh    <= w_lh;
            r_hl    <= w_hl;
            r_hh    <= w_hh;
            r_cross <= CROSS_W'(r_lh) + CROSS_W'(r_hl);
            r_low   <= r_ll;
            r_high  <= r_hh;
            r_z     <= PROD_W'(r_low) + (PROD_W'(r_cross) << HALF_W) + (PROD_W'(r_high) << OP_W);
        end
    end

    assign z = r_z;

`ifdef VEDIC_VALID_EN
    logic [PIPE_LAT-1:0] r_vld;

    // Valid bit rides alongside the data; the data path ignores it.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_LAT-2:0], in_valid};
        end
    end

    assign out_valid = r_vld[PIPE_LAT-1];
`endif

endmodule

// File: tb/tb_vedic_eight_pipeline.sv
// Self-checking bench for vedic_eight_pipeline: directed, streaming, reset and random sweeps.
module tb_vedic_eight_pipeline;

    logic        clk1;
    logic        rst_n;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [15:0] z;
`ifdef VEDIC_VALID_EN
    logic        in_valid;
    logic        out_valid;
`endif

    int n_checks;
    int n_fail;
    int exp_q[$];
    int vld_q[$];

    vedic_eight_pipeline dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .i(i),
        .j(j),
        .z(z)
`ifdef VEDIC_VALID_EN
        ,
        .in_valid(in_valid),
        .out_valid(out_valid)
`endif
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: products emerge three edges after they were sampled, zeros before.
    task automatic model_flush();
        exp_q = '{0, 0, 0};
        vld_q = '{0, 0, 0};
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
        int e;
        int ev;
        i = a;
        j = b;
`ifdef VEDIC_VALID_EN
        in_valid = v;
`endif
        @(posedge clk1);
        exp_q.push_back(int'(a) * int'(b));
        vld_q.push_back(int'(v));
        #1;
        e  = exp_q.pop_front();
        ev = vld_q.pop_front();
        check("z_model", 32'(z), 32'(e));
`ifdef VEDIC_VALID_EN
        check("out_valid_model", 32'(out_valid), 32'(ev));
`else
        if (ev < 0) n_fail++;
`endif
    endtask

    initial begin
        int da[5];
        int db[5];
        int dp[5];
        logic [7:0] ra;
        logic [7:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        i        = 8'd0;
        j        = 8'd0;
`ifdef VEDIC_VALID_EN
        in_valid = 1'b0;
`endif
        model_flush();
        #1;
        check("reset_z", 32'(z), 32'd0);
`ifdef VEDIC_VALID_EN
        check("reset_out_valid", 32'(out_valid), 32'd0);
`endif
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;

        // Zeros held, then 1*1 after four edges.
        repeat (5) step(8'd0, 8'd0, 1'b0);
        check("zero_hold", 32'(z), 32'd0);
        repeat (4) step(8'd1, 8'd1, 1'b0);
        check("one_times_one", 32'(z), 32'd1);
        repeat (4) step(8'd1, 8'd173, 1'b0);
        check("one_times_x", 32'(z), 32'd173);
        repeat (4) step(8'd0, 8'd255, 1'b0);
        check("zero_times_x", 32'(z), 32'd0);

        // Directed products held seven cycles.
        da = '{10, 170, 200, 240, 255};
        db = '{20, 204, 210, 250, 255};
        dp = '{200, 34680, 42000, 60000, 65025};
        for (int k = 0; k < 5; k++) begin
            repeat (7) step(8'(da[k]), 8'(db[k]), 1'b0);
            check("directed", 32'(z), 32'(dp[k]));
        end

        // Back-to-back stream, one result per cycle.
        step(8'd2, 8'd2, 1'b0);
        step(8'd3, 8'd3, 1'b0);
        step(8'd4, 8'd4, 1'b0);
        step(8'd255, 8'd255, 1'b0);
        check("stream_0", 32'(z), 32'd4);
        step(8'd0, 8'd0, 1'b0);
        check("stream_1", 32'(z), 32'd9);
        step(8'd0, 8'd0, 1'b0);
        check("stream_2", 32'(z), 32'd16);
        step(8'd0, 8'd0, 1'b0);
        check("stream_3", 32'(z), 32'd65025);

        // Mid-stream reset between edges flushes everything in flight.
        step(8'd99, 8'd77, 1'b1);
        step(8'd200, 8'd201, 1'b1);
        step(8'd250, 8'd251, 1'b1);
        step(8'd123, 8'd45, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_z", 32'(z), 32'd0);
`ifdef VEDIC_VALID_EN
        check("async_reset_vld", 32'(out_valid), 32'd0);
`endif
        repeat (2) begin
            @(posedge clk1);
            #1;
            check("held_reset_z", 32'(z), 32'd0);
        end
        rst_n = 1'b1;
        model_flush();
        repeat (3) step(8'd7, 8'd9, 1'b0);
        check("post_reset_flush", 32'(z), 32'd0);
        step(8'd7, 8'd9, 1'b0);
        check("post_reset_first", 32'(z), 32'd63);

`ifdef VEDIC_VALID_EN
        // Single valid pulse tracks its product.
        step(8'd75, 8'd85, 1'b1);
        repeat (2) step(8'd0, 8'd0, 1'b0);
        check("pulse_pre", 32'(out_valid), 32'd0);
        step(8'd0, 8'd0, 1'b0);
        check("pulse_vld", 32'(out_valid), 32'd1);
        check("pulse_z", 32'(z), 32'd6375);
        step(8'd0, 8'd0, 1'b0);
        check("pulse_post", 32'(out_valid), 32'd0);
`endif

        // Random sweep with occasional boundary operands.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: ra = 8'd0;
                1: rb = 8'd1;
                2: ra = 8'd255;
                default: ;
            endcase
            step(ra, rb, 1'($urandom_range(0, 1)));
        end
        repeat (4) step(8'd0, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic_eight_pipeline.md
VEDIC_EIGHT_PIPELINE -- requirements
Module: vedic_eight_pipeline

Interface
REQ-001 Parameters: none; widths are fixed constants taken from the shared package.
REQ-002 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i  input  8  unsigned multiplicand.
REQ-005 j  input  8  unsigned multiplier.
REQ-006 z  output  16  unsigned product i*j, registered.
REQ-007 Ports in_valid (input, 1) and out_valid (output, 1) SHALL exist only when VEDIC_VALID_EN is defined.

Function
REQ-008 z SHALL equal i*j, full 16-bit unsigned, with no truncation or overflow (max 255*255 = 65025).
REQ-009 Algorithm: Urdhva-Tiryagbhyam split, i = {ih,il}, j = {jh,jl} (4-bit halves); four 4x4 partial products; z = ll + ((lh + hl) << 4) + (hh << 8).
REQ-010 Stage 1: i and j are registered on a rising clk1 edge.
REQ-011 Stage 2: the four 8-bit partial products ll, lh, hl, hh are registered.
REQ-012 Stage 3: cross sum lh+hl (9 bits) and the low and high terms are registered.
REQ-013 Stage 4: the final 16-bit addition is registered into z.
REQ-014 Latency: operands sampled at rising edge N SHALL appear on z immediately after edge N+3, i.e. 4 register stages.
REQ-015 Throughput: one new operand pair per cycle; back-to-back operands SHALL emerge in order, one per cycle, with no bubbles.
REQ-016 No stall or enable input: the pipeline always advances.
REQ-017 Operands that are constant for at least 4 cycles SHALL leave z constant at their product.
REQ-018 Boundaries: 0*x = 0, 1*x = x, and 255*255 = 65025 SHALL be exact.

Reset
REQ-019 While rst_n = 0, every pipeline register and z SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 Reset during operation SHALL flush all in-flight products; none of them may appear on z afterwards.
REQ-021 After rst_n rises, the first valid z SHALL follow the REQ-014 latency, counted from the first sampling edge after release.
REQ-022 With VEDIC_VALID_EN, out_valid SHALL reset to 0.

Configuration
REQ-023 Macro VEDIC_VALID_EN defined: a 4-deep valid shift register tracks in_valid.
REQ-024 With VEDIC_VALID_EN, out_valid SHALL be high exactly in the cycle z holds the product of an operand pair sampled with in_valid = 1.
REQ-025 With VEDIC_VALID_EN, the data path is unaffected by in_valid; z still updates every cycle.
REQ-026 Macro VEDIC_VALID_EN undefined: neither valid port nor the valid register exists; behaviour is otherwise identical.

Structure
REQ-027 Shared package vedic_pkg SHALL hold:
- OP_W = 8
- HALF_W = 4
- PROD_W = 16
- PIPE_LAT = 4
- typedefs operand_t (8b), half_t (4b), pprod_t (8b), product_t (16b).
REQ-028 One sub-module, vedic_four: combinational 4x4 Vedic multiplier built from 2x2 Urdhva cells, with a 8-bit output.
REQ-029 vedic_eight_pipeline SHALL instantiate vedic_four four times; no other sub-modules.

Verification
REQ-030 Reset then i=0, j=0 held -> z=0; i=1, j=1 -> z=1 four cycles after sampling.
REQ-031 Directed products, each held 7 cycles, checking z:
- 10*20 -> 200
- 170*204 -> 34680
- 200*210 -> 42000
- 240*250 -> 60000
- 255*255 -> 65025
REQ-032 Back-to-back stream 2*2, 3*3, 4*4, 255*255 on consecutive edges -> z = 4, 9, 16, 65025 on consecutive cycles starting 4 cycles after the first edge.
REQ-033 rst_n asserted mid-stream between clock edges -> z=0 at once; no pre-reset product ever appears after release.
REQ-034 With VEDIC_VALID_EN: in_valid pulse for one cycle on 75*85 -> out_valid high for exactly one cycle with z=6375, 4 cycles later.
REQ-035 Randomized sweep of 1000 operand pairs against a latency-4 reference model -> zero mismatches.
